dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage.
- Serves the word load/store issued from the EX/MEM pipeline register.
- Stalls the pipeline on a miss while it sequences dirty-line writeback and line refill against a 256-bit-line main memory.
- Holds the tag and data arrays internally. All state updates on the rising edge of clk_i.

Parameters:
- INDEX_W, 5: index bits; number of lines = 2^INDEX_W (default 32).
- TAG_W, 22: tag bits; must equal 32 - INDEX_W - 5.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- p1_req_i  input  1  CPU access request (MemRead | MemWrite from the EX/MEM register)
- p1_write_i  input  1  1 = store, 0 = load
- p1_addr_i  input  32  byte address; [4:2] word select, [9:5] index, [31:10] tag
- p1_data_i  input  32  store data
- p1_data_o  output  32  load data
- p1_stall_o  output  1  pipeline stall
- mem_enable_o  output  1  memory request
- mem_write_o  output  1  1 = line write, 0 = line read
- mem_addr_o  output  32  line address, [4:0] = 0
- mem_data_o  output  256  writeback line
- mem_data_i  input  256  refill line
- mem_ack_i  input  1  memory completion, 1-cycle pulse

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Per-line state: valid, dirty, tag[TAG_W-1:0], data[255:0]. Word w of a line = bits [32w+31:32w]. p1_addr_i[1:0] ignored.
- Hit condition: valid[idx] && tag[idx] == addr tag. Evaluated combinationally in IDLE only.
- FSM states:
  - IDLE: main state.
  - WB: dirty writeback.
  - REFILL: line read.
  - FILLED: one cycle.
- IDLE, no request: p1_stall_o = 0.
- IDLE, request and hit:
  - p1_stall_o = 0 in the same cycle.
  - Load: p1_data_o = addressed word, combinational.
  - Store: at the clock edge write the word and set dirty.
- IDLE, request and miss:
  - p1_stall_o = 1 combinationally in the same cycle.
  - Next state is WB if valid && dirty, else REFILL.
- WB:
  - Drives mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {old tag, idx, 5'b0}, mem_data_o = line data.
  - Holds all of these until mem_ack_i, then goes to REFILL.
- REFILL:
  - Drives mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {new tag, idx, 5'b0}.
  - On mem_ack_i: line data = mem_data_i, tag = new tag, valid = 1, dirty = 0; next state is FILLED.
- FILLED:
  - p1_stall_o = 1, mem_enable_o = 0; next state is IDLE.
  - In IDLE the access is re-evaluated and hits.
  - A store miss therefore completes as a write hit on the retry cycle.
- p1_stall_o = 1 in every state other than IDLE. mem_enable_o = 0 in IDLE and FILLED.
- CPU inputs during a miss:
  - Held stable by the stalled pipeline.
  - The controller latches the miss address at IDLE→WB/REFILL and uses the latched value for mem_addr_o and the tag update.
  - If p1_req_i drops mid-miss, the refill still completes; no stall occurs on return to IDLE.
- mem_ack_i in IDLE or FILLED is ignored.
- A miss never returns to IDLE without completing its refill.
- Reset:
  - Outputs: p1_stall_o = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, p1_data_o = 0 while no request.
  - FSM goes to IDLE; all valid and dirty bits clear. Data and tag arrays need not clear.
  - Reset mid-WB or mid-REFILL aborts the transaction: mem_enable_o = 0 from the next cycle, and a subsequent ack is ignored.
- No multi-request queueing; one outstanding memory transaction maximum.

Test Plan:
- Reset, then load 0x0000_0400 → p1_stall_o = 1 same cycle, then REFILL with mem_addr_o = 0x0000_0400, mem_write_o = 0. Ack with line word0 = 0xDEAD_BEEF → FILLED, then IDLE hit: p1_data_o = 0xDEAD_BEEF, stall 0.
- Store 0x1234_5678 to 0x0000_0404 (hit) → no stall. Load 0x0000_0404 returns 0x1234_5678; dirty set.
- Load 0x0000_0800 (same index 0, tag 2) → WB with mem_addr_o = 0x0000_0400, mem_write_o = 1, mem_data_o word1 = 0x1234_5678, held 5 cycles until ack → REFILL at 0x0000_0800 → FILLED → hit.
- Store miss to clean line 0x0000_0020 → REFILL only, no WB; retry cycle writes the word. Load returns stored data.
- Assert rst_i while in REFILL before ack → next cycle mem_enable_o = 0, stall 0. A late ack is ignored; a reload of the same address misses again.
- Drop p1_req_i during REFILL → refill completes, line becomes valid, and the return to IDLE produces no stall.

Source files
------------

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Direct-mapped, write-back, write-allocate data cache controller
//            for the MEM stage. Stalls the pipeline on a miss while it writes
//            back a dirty victim line and refills the line from memory.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 22
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         p1_req_i,
    input  logic         p1_write_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2,
        S_FILLED = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [255:0]       data_q [LINES];

    // Miss address captured when leaving IDLE; the CPU address is not trusted
    // for the rest of the miss sequence.
    logic [TAG_W-1:0]   miss_tag_q;
    logic [INDEX_W-1:0] miss_idx_q;

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         req_word;
    logic               hit;
    logic               store_hit;
    logic               miss_start;
    logic               refill_done;
    logic               unused_addr_lsb;

    assign req_idx         = p1_addr_i[INDEX_W+4:5];
    assign req_tag         = p1_addr_i[31:INDEX_W+5];
    assign req_word        = p1_addr_i[4:2];
    assign unused_addr_lsb = ^p1_addr_i[1:0];

    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign store_hit   = (state_q == S_IDLE) && p1_req_i && p1_write_i && hit;
    assign miss_start  = (state_q == S_IDLE) && p1_req_i && !hit;
    assign refill_done = (state_q == S_REFILL) && mem_ack_i;

    // Next-state logic and all CPU/memory-side outputs
    always_comb begin
        state_d      = state_q;
        p1_stall_o   = 1'b0;
        p1_data_o    = 32'd0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = 256'd0;
        case (state_q)
            S_IDLE: begin
                if (p1_req_i) begin
                    if (hit) begin
                        if (!p1_write_i) begin
                            p1_data_o = data_q[req_idx][{req_word, 5'b00000} +: 32];
                        end
                    end else begin
                        p1_stall_o = 1'b1;
                        state_d    = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB : S_REFILL;
                    end
                end
            end
            S_WB: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, 5'b00000};
                mem_data_o   = data_q[miss_idx_q];
                if (mem_ack_i) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {miss_tag_q, miss_idx_q, 5'b00000};
                if (mem_ack_i) begin
                    state_d = S_FILLED;
                end
            end
            S_FILLED: begin
                p1_stall_o = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, line status bits and latched miss address
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
            end
            if (store_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (refill_done) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays: no reset, contents are qualified by valid_q
    always_ff @(posedge clk_i) begin
        if (!rst_i && store_hit) begin
            data_q[req_idx][{req_word, 5'b00000} +: 32] <= p1_data_i;
        end
        if (!rst_i && refill_done) begin
            data_q[miss_idx_q] <= mem_data_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Scoreboard bench for dcache_ctrl. A transaction-level model
//            (flat line memory plus per-index line bookkeeping) predicts memory
//            transactions and load data; a monitor compares DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic         clk;
    logic         rst_i;
    logic         p1_req_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_ctrl #(.INDEX_W(5), .TAG_W(22)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } mtx_t;

    mtx_t         mq[$];      // expected memory transactions, in order
    logic [31:0]  lq[$];      // expected load data, in order
    string        cname[$];   // driver-side observations for the monitor
    logic [255:0] cact[$];
    logic [255:0] cexp[$];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  done     = 1'b0;
    bit  hold_ack = 1'b0;
    int  ack_delay = -1;
    int  late_ack_cnt = 0;

    // Reference model state
    logic [255:0] rmem [logic [26:0]];
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];

    function automatic logic [255:0] init_line(input logic [26:0] ln);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = (32'(ln) * 32'd8 + 32'(w)) ^ 32'hC0DE_0000;
        end
        return l;
    endfunction

    function automatic logic [255:0] preload_line(input logic [26:0] ln);
        logic [255:0] l;
        l = init_line(ln);
        if (ln == 27'h20) l[31:0] = 32'hDEAD_BEEF;
        return l;
    endfunction

    function automatic logic [255:0] rget(input logic [26:0] ln);
        return rmem.exists(ln) ? rmem[ln] : preload_line(ln);
    endfunction

    task automatic dchk(input string n, input logic [255:0] a, input logic [255:0] e);
        cname.push_back(n);
        cact.push_back(a);
        cexp.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Transaction-level prediction of one CPU access
    task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input bit push_load, output bit hit);
        logic [4:0]  idx;
        logic [21:0] tg;
        int          w;
        mtx_t        e;
        idx = a[9:5];
        tg  = a[31:10];
        w   = int'(a[4:2]);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                e.wr = 1'b1; e.addr = {m_tag[idx], idx, 5'b0}; e.data = m_data[idx];
                mq.push_back(e);
                rmem[{m_tag[idx], idx}] = m_data[idx];
            end
            e.wr = 1'b0; e.addr = {tg, idx, 5'b0}; e.data = '0;
            mq.push_back(e);
            m_data[idx]  = rget({tg, idx});
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_data[idx][w*32 +: 32] = d;
            m_dirty[idx] = 1'b1;
        end else if (push_load) begin
            lq.push_back(m_data[idx][w*32 +: 32]);
        end
    endtask

    // One CPU access, held until the controller releases the stall
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit hit;
        int cnt;
        model_access(wr, a, d, 1'b1, hit);
        p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
        @(negedge clk); #1;
        dchk("stall_first_cycle", 256'(p1_stall_o), 256'(!hit));
        cnt = 0;
        while (p1_stall_o && cnt < 200) begin
            @(negedge clk); #1;
            cnt++;
        end
        if (cnt >= 200) dchk("stall_timeout", 256'd1, 256'd0);
        @(posedge clk); #1;
        p1_req_i = 1'b0;
    endtask

    task automatic wait_enable(input bit level, input string n);
        int cnt;
        cnt = 0;
        while ((mem_enable_o != level) && cnt < 50) begin
            @(negedge clk); #1;
            cnt++;
        end
        if (cnt >= 50) dchk(n, 256'(mem_enable_o), 256'(level));
    endtask

    // Memory responder: random ack latency, one-cycle ack pulse
    initial begin
        logic [255:0] bmem [logic [26:0]];
        int seen_late;
        int dl;
        seen_late  = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (late_ack_cnt != seen_late) begin
                seen_late = late_ack_cnt;
                mem_ack_i = 1'b1;
                @(negedge clk);
                mem_ack_i = 1'b0;
            end else if (mem_enable_o && !hold_ack && !rst_i) begin
                dl = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 4));
                repeat (dl) @(negedge clk);
                if (mem_write_o) bmem[mem_addr_o[31:5]] = mem_data_o;
                else mem_data_i = bmem.exists(mem_addr_o[31:5]) ? bmem[mem_addr_o[31:5]]
                                                               : preload_line(mem_addr_o[31:5]);
                mem_ack_i = 1'b1;
                @(negedge clk);
                mem_ack_i = 1'b0;
            end
        end
    end

    // Monitor: compares memory requests and load data against the scoreboard
    initial begin
        mtx_t e;
        logic [31:0] le;
        forever begin
            @(negedge clk); #2;
            if (!rst_i && mem_enable_o) begin
                n_checks++;
                if (mq.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_unexpected: got request addr %h wr %0d, expected none",
                             mem_addr_o, mem_write_o);
                end else begin
                    e = mq[0];
                    if (mem_write_o !== e.wr || mem_addr_o !== e.addr ||
                        (e.wr && mem_data_o !== e.data)) begin
                        n_fail++;
                        $display("FAIL mem_req: got wr %0d addr %h data %h, expected wr %0d addr %h data %h",
                                 mem_write_o, mem_addr_o, mem_data_o, e.wr, e.addr, e.data);
                    end
                    if (mem_ack_i) void'(mq.pop_front());
                end
            end
            if (!rst_i && p1_req_i && !p1_write_i && !p1_stall_o) begin
                n_checks++;
                if (lq.size() == 0) begin
                    n_fail++;
                    $display("FAIL load_unexpected: got data %h, expected no load", p1_data_o);
                end else begin
                    le = lq.pop_front();
                    if (p1_data_o !== le) begin
                        n_fail++;
                        $display("FAIL load_data: addr %h got %h expected %h", p1_addr_i, p1_data_o, le);
                    end
                end
            end
            while (cname.size() > 0) begin
                string       n;
                logic [255:0] a, x;
                n = cname.pop_front(); a = cact.pop_front(); x = cexp.pop_front();
                n_checks++;
                if (a !== x) begin
                    n_fail++;
                    $display("FAIL %s: got %0h expected %0h", n, a, x);
                end
            end
            if (done) begin
                n_checks++;
                if (mq.size() != 0 || lq.size() != 0) begin
                    n_fail++;
                    $display("FAIL queues_drained: got %0d mem / %0d load pending, expected 0 / 0",
                             mq.size(), lq.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        bit hit;
        logic [4:0] idx_set [4];
        idx_set = '{5'd0, 5'd1, 5'd2, 5'd31};
        rst_i = 1'b1; p1_req_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        dchk("rst_stall",    256'(p1_stall_o),   256'd0);
        dchk("rst_enable",   256'(mem_enable_o), 256'd0);
        dchk("rst_write",    256'(mem_write_o),  256'd0);
        dchk("rst_addr",     256'(mem_addr_o),   256'd0);
        dchk("rst_mem_data", mem_data_o,         256'd0);
        dchk("rst_p1_data",  256'(p1_data_o),    256'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Cold load miss, store hit, load back
        access(1'b0, 32'h0000_0400, 32'd0);
        access(1'b1, 32'h0000_0404, 32'h1234_5678);
        access(1'b0, 32'h0000_0404, 32'd0);
        // Dirty eviction with a slow memory
        ack_delay = 5;
        access(1'b0, 32'h0000_0800, 32'd0);
        ack_delay = -1;
        // Store miss to a clean line, then load it back
        access(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        access(1'b0, 32'h0000_0020, 32'd0);

        // Reset while REFILL waits for its ack
        hold_ack = 1'b1;
        model_access(1'b0, 32'h0000_0C40, 32'd0, 1'b0, hit);
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0C40;
        @(negedge clk); #1;
        wait_enable(1'b1, "refill_start_timeout");
        dchk("refill_stall", 256'(p1_stall_o), 256'd1);
        @(posedge clk); #1;
        rst_i = 1'b1; p1_req_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_reset();
        mq.delete(); lq.delete();
        @(negedge clk); #1;
        dchk("abort_enable", 256'(mem_enable_o), 256'd0);
        dchk("abort_stall",  256'(p1_stall_o),   256'd0);
        late_ack_cnt++;
        repeat (3) @(negedge clk);
        #1;
        dchk("late_ack_enable", 256'(mem_enable_o), 256'd0);
        dchk("late_ack_stall",  256'(p1_stall_o),   256'd0);
        hold_ack = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 32'h0000_0C40, 32'd0);
        access(1'b0, 32'h0000_0404, 32'd0);

        // Request withdrawn mid-refill
        model_access(1'b0, 32'h0000_1060, 32'd0, 1'b0, hit);
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_1060;
        @(negedge clk); #1;
        wait_enable(1'b1, "drop_start_timeout");
        @(posedge clk); #1;
        p1_req_i = 1'b0;
        @(negedge clk); #1;
        wait_enable(1'b0, "drop_end_timeout");
        @(negedge clk); #1;
        dchk("drop_idle_stall", 256'(p1_stall_o), 256'd0);
        @(negedge clk); #1;
        dchk("drop_idle_stall2", 256'(p1_stall_o),   256'd0);
        dchk("drop_idle_enable", 256'(mem_enable_o), 256'd0);
        @(posedge clk); #1;
        access(1'b0, 32'h0000_1060, 32'd0);

        // Randomized traffic over a few conflicting indices
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {22'($urandom_range(0, 3)), idx_set[$urandom_range(0, 3)],
                 3'($urandom_range(0, 7)), 2'b00};
            access(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        done = 1'b1;
    end

endmodule
`default_nettype wire
